// File: rtl/pipe_issue_ctrl_if.sv
// ---------------------------------------------------------------------------
// pipe_issue_ctrl_if
// Bundle between the instruction sources, the issue controller and the
// pipeline datapath.
//   req0_* / req1_* : two requesters, valid/ready handshake plus the
//                     instruction fields (f, rs1, rs2, rd, addr)
//   iss_*           : registered instruction presented to the pipeline
// Modports:
//   master : requester/pipeline side (drives requests, sees ready and iss_*)
//   slave  : pipe_issue_ctrl side
// ---------------------------------------------------------------------------
interface pipe_issue_ctrl_if #(
    parameter int M   = 3,
    parameter int FUN = 3,
    parameter int ADR = 8
);
    logic           req0_valid;
    logic           req0_ready;
    logic [FUN-1:0] req0_f;
    logic [M-1:0]   req0_rs1;
    logic [M-1:0]   req0_rs2;
    logic [M-1:0]   req0_rd;
    logic [ADR-1:0] req0_addr;

    logic           req1_valid;
    logic           req1_ready;
    logic [FUN-1:0] req1_f;
    logic [M-1:0]   req1_rs1;
    logic [M-1:0]   req1_rs2;
    logic [M-1:0]   req1_rd;
    logic [ADR-1:0] req1_addr;

    logic           iss_valid;
    logic           iss_src;
    logic [FUN-1:0] iss_f;
    logic [M-1:0]   iss_rs1;
    logic [M-1:0]   iss_rs2;
    logic [M-1:0]   iss_rd;
    logic [ADR-1:0] iss_addr;

    modport master (
        output req0_valid, req0_f, req0_rs1, req0_rs2, req0_rd, req0_addr,
        output req1_valid, req1_f, req1_rs1, req1_rs2, req1_rd, req1_addr,
        input  req0_ready, req1_ready,
        input  iss_valid, iss_src, iss_f, iss_rs1, iss_rs2, iss_rd, iss_addr
    );

    modport slave (
        input  req0_valid, req0_f, req0_rs1, req0_rs2, req0_rd, req0_addr,
        input  req1_valid, req1_f, req1_rs1, req1_rs2, req1_rd, req1_addr,
        output req0_ready, req1_ready,
        output iss_valid, iss_src, iss_f, iss_rs1, iss_rs2, iss_rd, iss_addr
    );
endinterface

// File: rtl/pipe_issue_ctrl.sv
// ---------------------------------------------------------------------------
// pipe_issue_ctrl
// Issue controller for the read / ALU / writeback / store pipeline. Two
// requesters are arbitrated round-robin; a destination scoreboard holds back
// instructions whose used sources are still being produced. One registered
// instruction per cycle is driven onto iss_*.
//
// Ports:
//   clk        : clock, all state on rising edge
//   rst_n      : asynchronous active-low reset
//   bus        : pipe_issue_ctrl_if.slave (requests, readies, iss_* outputs)
//   issue_cnt  : saturating handshake count   (only with PIPE_PERF_EN)
//   stall_cnt  : saturating stall-cycle count (only with PIPE_PERF_EN)
//
// Optional feature macro: PIPE_PERF_EN adds the two performance counters.
// ---------------------------------------------------------------------------
module pipe_issue_ctrl #(
    parameter int M      = 3,
    parameter int FUN    = 3,
    parameter int ADR    = 8,
    parameter int WB_LAT = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    pipe_issue_ctrl_if.slave bus
`ifdef PIPE_PERF_EN
    ,
    output logic [15:0]      issue_cnt,
    output logic [15:0]      stall_cnt
`endif
);
    typedef enum logic {
        PTR_REQ0 = 1'b0,
        PTR_REQ1 = 1'b1
    } ptr_t;

    localparam logic [FUN-1:0] F_NOT_A = FUN'(6);  // uses rs1 only
    localparam logic [FUN-1:0] F_NOT_B = FUN'(7);  // uses rs2 only

    // The oldest slot of the WB_LAT-deep chain never blocks: a consumer
    // accepted while its producer sits there reads operands after the
    // producer's writeback. Only the younger WB_LAT-1 slots need storage.
    localparam int SB_D = (WB_LAT > 1) ? WB_LAT - 1 : 1;

    function automatic logic src_hit(input logic [FUN-1:0] f,
                                     input logic [M-1:0]   rs1,
                                     input logic [M-1:0]   rs2,
                                     input logic [M-1:0]   rd);
        return ((f != F_NOT_B) && (rs1 == rd)) ||
               ((f != F_NOT_A) && (rs2 == rd));
    endfunction

    ptr_t           ptr_reg, ptr_next;
    logic           hz0, hz1;
    logic           ok0, ok1;
    logic           grant0, grant1;
    logic           hs;

    logic [FUN-1:0] sel_f;
    logic [M-1:0]   sel_rs1, sel_rs2, sel_rd;
    logic [ADR-1:0] sel_addr;

    logic           iss_valid_reg;
    logic           iss_src_reg;
    logic [FUN-1:0] iss_f_reg;
    logic [M-1:0]   iss_rs1_reg, iss_rs2_reg, iss_rd_reg;
    logic [ADR-1:0] iss_addr_reg;

    // -----------------------------------------------------------------------
    // Scoreboard shift chain and hazard detection
    // -----------------------------------------------------------------------
    genvar gi;
    generate
        if (WB_LAT > 1) begin : g_sb
            logic [SB_D-1:0]        sb_valid_reg;
            logic [SB_D-1:0][M-1:0] sb_rd_reg;
            logic [SB_D-1:0]        hit0, hit1;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    sb_valid_reg <= '0;
                    sb_rd_reg    <= '0;
                end else begin
                    sb_valid_reg[0] <= hs;
                    sb_rd_reg[0]    <= sel_rd;
                    for (int k = 1; k < SB_D; k++) begin
                        sb_valid_reg[k] <= sb_valid_reg[k-1];
                        sb_rd_reg[k]    <= sb_rd_reg[k-1];
                    end
                end
            end

            for (gi = 0; gi < SB_D; gi++) begin : g_hit
                assign hit0[gi] = sb_valid_reg[gi] &&
                    src_hit(bus.req0_f, bus.req0_rs1, bus.req0_rs2, sb_rd_reg[gi]);
                assign hit1[gi] = sb_valid_reg[gi] &&
                    src_hit(bus.req1_f, bus.req1_rs1, bus.req1_rs2, sb_rd_reg[gi]);
            end

            assign hz0 = |hit0;
            assign hz1 = |hit1;
        end else begin : g_no_sb
            assign hz0 = 1'b0;
            assign hz1 = 1'b0;
        end
    endgenerate

    // -----------------------------------------------------------------------
    // Round-robin arbitration; a blocked requester yields to the other one
    // -----------------------------------------------------------------------
    assign ok0 = bus.req0_valid && !hz0;
    assign ok1 = bus.req1_valid && !hz1;

    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
        if (ptr_reg == PTR_REQ0) begin
            grant0 = ok0;
            grant1 = ok1 && !ok0;
        end else begin
            grant1 = ok1;
            grant0 = ok0 && !ok1;
        end
    end

    assign hs             = grant0 || grant1;
    assign bus.req0_ready = grant0;
    assign bus.req1_ready = grant1;

    // Priority moves to the requester that was not just served
    always_comb begin
        ptr_next = ptr_reg;
        if (grant0) begin
            ptr_next = PTR_REQ1;
        end else if (grant1) begin
            ptr_next = PTR_REQ0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_reg <= PTR_REQ0;
        end else begin
            ptr_reg <= ptr_next;
        end
    end

    // -----------------------------------------------------------------------
    // Issue register
    // -----------------------------------------------------------------------
    always_comb begin
        sel_f    = bus.req0_f;
        sel_rs1  = bus.req0_rs1;
        sel_rs2  = bus.req0_rs2;
        sel_rd   = bus.req0_rd;
        sel_addr = bus.req0_addr;
        if (grant1) begin
            sel_f    = bus.req1_f;
            sel_rs1  = bus.req1_rs1;
            sel_rs2  = bus.req1_rs2;
            sel_rd   = bus.req1_rd;
            sel_addr = bus.req1_addr;
        end
    end

    // Fields hold their last value when nothing issues; only iss_valid drops
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            iss_valid_reg <= 1'b0;
            iss_src_reg   <= 1'b0;
            iss_f_reg     <= '0;
            iss_rs1_reg   <= '0;
            iss_rs2_reg   <= '0;
            iss_rd_reg    <= '0;
            iss_addr_reg  <= '0;
        end else begin
            iss_valid_reg <= hs;
            if (hs) begin
                iss_src_reg  <= grant1;
                iss_f_reg    <= sel_f;
                iss_rs1_reg  <= sel_rs1;
                iss_rs2_reg  <= sel_rs2;
                iss_rd_reg   <= sel_rd;
                iss_addr_reg <= sel_addr;
            end
        end
    end

    assign bus.iss_valid = iss_valid_reg;
    assign bus.iss_src   = iss_src_reg;
    assign bus.iss_f     = iss_f_reg;
    assign bus.iss_rs1   = iss_rs1_reg;
    assign bus.iss_rs2   = iss_rs2_reg;
    assign bus.iss_rd    = iss_rd_reg;
    assign bus.iss_addr  = iss_addr_reg;

    // -----------------------------------------------------------------------
    // Performance counters
    // -----------------------------------------------------------------------
`ifdef PIPE_PERF_EN
    logic        stall;
    logic [15:0] issue_cnt_reg, stall_cnt_reg;

    assign stall = (bus.req0_valid || bus.req1_valid) && !hs;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            issue_cnt_reg <= '0;
            stall_cnt_reg <= '0;
        end else begin
            if (hs && (issue_cnt_reg != 16'hFFFF)) begin
                issue_cnt_reg <= issue_cnt_reg + 16'd1;
            end
            if (stall && (stall_cnt_reg != 16'hFFFF)) begin
                stall_cnt_reg <= stall_cnt_reg + 16'd1;
            end
        end
    end

    assign issue_cnt = issue_cnt_reg;
    assign stall_cnt = stall_cnt_reg;
`endif

endmodule

// File: tb/tb_pipe_issue_ctrl.sv
`timescale 1ns/1ps
module tb_pipe_issue_ctrl;
    localparam int M      = 3;
    localparam int FUN    = 3;
    localparam int ADR    = 8;
    localparam int WB_LAT = 2;
    localparam int NREG   = 1 << M;

    typedef struct packed {
        logic           v;
        logic [FUN-1:0] f;
        logic [M-1:0]   rs1;
        logic [M-1:0]   rs2;
        logic [M-1:0]   rd;
        logic [ADR-1:0] addr;
    } req_t;

    typedef struct packed {
        logic           valid;
        logic           src;
        logic [FUN-1:0] f;
        logic [M-1:0]   rs1;
        logic [M-1:0]   rs2;
        logic [M-1:0]   rd;
        logic [ADR-1:0] addr;
    } iss_t;

    localparam req_t IDLE = '0;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    pipe_issue_ctrl_if #(.M(M), .FUN(FUN), .ADR(ADR)) bus ();

`ifdef PIPE_PERF_EN
    logic [15:0] issue_cnt, stall_cnt;
`endif

    pipe_issue_ctrl #(.M(M), .FUN(FUN), .ADR(ADR), .WB_LAT(WB_LAT)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus)
`ifdef PIPE_PERF_EN
        ,
        .issue_cnt (issue_cnt),
        .stall_cnt (stall_cnt)
`endif
    );

    iss_t obs_iss;
    assign obs_iss = {bus.iss_valid, bus.iss_src, bus.iss_f, bus.iss_rs1,
                      bus.iss_rs2, bus.iss_rd, bus.iss_addr};

    int chk = 0;
    int err = 0;

    // Reference model: a register is unreadable until WB_LAT edges after the
    // edge that accepted its producer.
    int   m_edge;
    logic m_ptr;
    int   last_wr [NREG];
    iss_t m_iss;
    int   m_issue, m_stall;
    req_t cur_a, cur_b;
    logic e_rdy0, e_rdy1;

    function automatic req_t mk(input logic [FUN-1:0] f, input logic [M-1:0] rs1,
                                input logic [M-1:0] rs2, input logic [M-1:0] rd);
        req_t r;
        r.v    = 1'b1;
        r.f    = f;
        r.rs1  = rs1;
        r.rs2  = rs2;
        r.rd   = rd;
        r.addr = ADR'($urandom);
        return r;
    endfunction

    function automatic bit m_blocked(input req_t r);
        bit use1 = (r.f != 3'b111);
        bit use2 = (r.f != 3'b110);
        return (use1 && (m_edge - last_wr[r.rs1] < WB_LAT)) ||
               (use2 && (m_edge - last_wr[r.rs2] < WB_LAT));
    endfunction

    task automatic model_reset();
        m_edge  = 0;
        m_ptr   = 1'b0;
        for (int i = 0; i < NREG; i++) last_wr[i] = -100;
        m_iss   = '0;
        m_issue = 0;
        m_stall = 0;
    endtask

    // Drive both requesters and predict the readies; returns 1 ns later
    task automatic apply(input req_t a, input req_t b);
        bit ok0, ok1;
        cur_a = a;
        cur_b = b;
        bus.req0_valid = a.v; bus.req0_f = a.f; bus.req0_rs1 = a.rs1;
        bus.req0_rs2 = a.rs2; bus.req0_rd = a.rd; bus.req0_addr = a.addr;
        bus.req1_valid = b.v; bus.req1_f = b.f; bus.req1_rs1 = b.rs1;
        bus.req1_rs2 = b.rs2; bus.req1_rd = b.rd; bus.req1_addr = b.addr;
        ok0 = a.v && !m_blocked(a);
        ok1 = b.v && !m_blocked(b);
        if (m_ptr == 1'b0) begin
            e_rdy0 = ok0;
            e_rdy1 = ok1 && !ok0;
        end else begin
            e_rdy1 = ok1;
            e_rdy0 = ok0 && !ok1;
        end
        #1;
    endtask

    // Clock edge plus model update; returns 1 ns after the edge
    task automatic advance();
        req_t r;
        @(posedge clk);
        if (e_rdy0 || e_rdy1) begin
            r = e_rdy1 ? cur_b : cur_a;
            last_wr[r.rd] = m_edge;
            m_ptr = ~e_rdy1;
            m_iss = {1'b1, e_rdy1, r.f, r.rs1, r.rs2, r.rd, r.addr};
            if (m_issue < 65535) m_issue++;
            $display("[%0t] issue src=%0d f=%0d rs1=%0d rs2=%0d rd=%0d addr=%02h",
                     $time, e_rdy1, r.f, r.rs1, r.rs2, r.rd, r.addr);
        end else begin
            m_iss.valid = 1'b0;
            if ((cur_a.v || cur_b.v) && m_stall < 65535) m_stall++;
        end
        m_edge++;
        #1;
    endtask

    task automatic drain();
        for (int i = 0; i < WB_LAT; i++) begin
            apply(IDLE, IDLE);
            advance();
        end
    endtask

    task automatic test_reset();
        model_reset();
        apply(IDLE, IDLE);
        rst_n = 1'b0;
        #1;
        chk++;
        if (obs_iss !== '0) begin
            err++; $display("FAIL reset_outputs: got %h expected 0", obs_iss);
        end
        #21 rst_n = 1'b1;
        apply(IDLE, IDLE);
        chk++;
        if ({bus.req0_ready, bus.req1_ready} !== {e_rdy0, e_rdy1}) begin
            err++; $display("FAIL reset_ready: got %b%b expected %b%b",
                            bus.req0_ready, bus.req1_ready, e_rdy0, e_rdy1);
        end
        advance();
        chk++;
        if (obs_iss !== m_iss) begin
            err++; $display("FAIL reset_idle_iss: got %h expected %h", obs_iss, m_iss);
        end
`ifdef PIPE_PERF_EN
        chk++;
        if (issue_cnt !== 16'd0 || stall_cnt !== 16'd0) begin
            err++; $display("FAIL reset_counters: got %0d/%0d expected 0/0", issue_cnt, stall_cnt);
        end
`endif
    endtask

    task automatic test_alternate();
        req_t a = mk(3'b000, 3'd2, 3'd3, 3'd1);
        req_t b = mk(3'b000, 3'd5, 3'd6, 3'd4);
        for (int k = 0; k < 8; k++) begin
            apply(a, b);
            chk++;
            if ({bus.req0_ready, bus.req1_ready} !== ((k % 2 == 0) ? 2'b10 : 2'b01) ||
                {bus.req0_ready, bus.req1_ready} !== {e_rdy0, e_rdy1}) begin
                err++; $display("FAIL alternate_ready k=%0d: got %b%b expected %b",
                                k, bus.req0_ready, bus.req1_ready, (k % 2 == 0) ? 2'b10 : 2'b01);
            end
            advance();
            chk++;
            if (obs_iss !== m_iss || bus.iss_src !== 1'(k % 2) || bus.iss_valid !== 1'b1) begin
                err++; $display("FAIL alternate_iss k=%0d: got %h expected %h", k, obs_iss, m_iss);
            end
        end
    endtask

    task automatic test_raw_hazard();
        req_t prod = mk(3'b000, 3'd1, 3'd2, 3'd3);
        req_t cons = mk(3'b000, 3'd3, 3'd0, 3'd7);
        int   stalls = 0;
        bit   accepted = 1'b0;
        drain();
        apply(prod, IDLE);
        advance();
        chk++;
        if (obs_iss !== m_iss) begin
            err++; $display("FAIL raw_producer_iss: got %h expected %h", obs_iss, m_iss);
        end
        for (int n = 0; n < 6 && !accepted; n++) begin
            apply(cons, IDLE);
            chk++;
            if ({bus.req0_ready, bus.req1_ready} !== {e_rdy0, e_rdy1}) begin
                err++; $display("FAIL raw_ready n=%0d: got %b%b expected %b%b",
                                n, bus.req0_ready, bus.req1_ready, e_rdy0, e_rdy1);
            end
            if (bus.req0_ready === 1'b1) accepted = 1'b1;
            else stalls++;
            advance();
            chk++;
            if (obs_iss !== m_iss) begin
                err++; $display("FAIL raw_iss n=%0d: got %h expected %h", n, obs_iss, m_iss);
            end
        end
        chk++;
        if (!accepted || stalls != WB_LAT - 1) begin
            err++; $display("FAIL raw_latency: accepted=%0d stalls=%0d expected accepted=1 stalls=%0d",
                            accepted, stalls, WB_LAT - 1);
        end
`ifdef PIPE_PERF_EN
        chk++;
        if (stall_cnt !== 16'(m_stall) || stall_cnt !== 16'd1) begin
            err++; $display("FAIL raw_stall_cnt: got %0d expected 1", stall_cnt);
        end
`endif
    endtask

    task automatic test_hazard_bypass();
        req_t prod = mk(3'b000, 3'd1, 3'd2, 3'd5);
        req_t a    = mk(3'b000, 3'd1, 3'd5, 3'd6);
        req_t b    = mk(3'b000, 3'd2, 3'd3, 3'd7);
        drain();
        apply(IDLE, prod);
        advance();
        apply(a, b);
        chk++;
        if ({bus.req0_ready, bus.req1_ready} !== 2'b01 ||
            {bus.req0_ready, bus.req1_ready} !== {e_rdy0, e_rdy1}) begin
            err++; $display("FAIL bypass_ready: got %b%b expected 01", bus.req0_ready, bus.req1_ready);
        end
        advance();
        chk++;
        if (obs_iss !== m_iss) begin
            err++; $display("FAIL bypass_iss: got %h expected %h", obs_iss, m_iss);
        end
        apply(a, IDLE);
        chk++;
        if (bus.req0_ready !== 1'b1) begin
            err++; $display("FAIL bypass_release: got ready0=%b expected 1", bus.req0_ready);
        end
        advance();
        chk++;
        if (obs_iss !== m_iss) begin
            err++; $display("FAIL bypass_release_iss: got %h expected %h", obs_iss, m_iss);
        end
    endtask

    task automatic test_src_decode();
        req_t prod = mk(3'b000, 3'd1, 3'd2, 3'd6);
        req_t c_a  = mk(3'b110, 3'd1, 3'd6, 3'd7);
        req_t c_b  = mk(3'b111, 3'd1, 3'd6, 3'd7);
        drain();
        apply(prod, IDLE);
        advance();
        apply(c_a, IDLE);
        chk++;
        if (bus.req0_ready !== 1'b1) begin
            err++; $display("FAIL decode_not_a: got ready0=%b expected 1", bus.req0_ready);
        end
        advance();
        drain();
        apply(prod, IDLE);
        advance();
        apply(c_b, IDLE);
        chk++;
        if (bus.req0_ready !== 1'b0) begin
            err++; $display("FAIL decode_not_b: got ready0=%b expected 0", bus.req0_ready);
        end
        advance();
        apply(c_b, IDLE);
        chk++;
        if (bus.req0_ready !== 1'b1) begin
            err++; $display("FAIL decode_not_b_release: got ready0=%b expected 1", bus.req0_ready);
        end
        advance();
        chk++;
        if (obs_iss !== m_iss) begin
            err++; $display("FAIL decode_iss: got %h expected %h", obs_iss, m_iss);
        end
    endtask

    task automatic test_reset_mid();
        req_t p1   = mk(3'b000, 3'd1, 3'd3, 3'd2);
        req_t p2   = mk(3'b000, 3'd1, 3'd3, 3'd4);
        req_t cons = mk(3'b000, 3'd4, 3'd2, 3'd5);
        drain();
        apply(p1, IDLE);
        advance();
        apply(p2, IDLE);
        advance();
        apply(IDLE, IDLE);
        #1 rst_n = 1'b0;
        #1;
        chk++;
        if (obs_iss !== '0) begin
            err++; $display("FAIL reset_mid_async: got %h expected 0", obs_iss);
        end
        model_reset();
        @(posedge clk);
        #2 rst_n = 1'b1;
        apply(cons, IDLE);
        chk++;
        if (bus.req0_ready !== 1'b1 || e_rdy0 !== 1'b1) begin
            err++; $display("FAIL reset_mid_no_stall: got ready0=%b expected 1", bus.req0_ready);
        end
        advance();
        chk++;
        if (obs_iss !== m_iss) begin
            err++; $display("FAIL reset_mid_iss: got %h expected %h", obs_iss, m_iss);
        end
`ifdef PIPE_PERF_EN
        chk++;
        if (issue_cnt !== 16'd1 || stall_cnt !== 16'd0) begin
            err++; $display("FAIL reset_mid_counters: got %0d/%0d expected 1/0", issue_cnt, stall_cnt);
        end
`endif
    endtask

    task automatic test_random();
        for (int n = 0; n < 400; n++) begin
            req_t a, b;
            a = mk(FUN'($urandom), M'($urandom), M'($urandom), M'($urandom));
            b = mk(FUN'($urandom), M'($urandom), M'($urandom), M'($urandom));
            a.v = ($urandom_range(0, 3) != 0);
            b.v = ($urandom_range(0, 3) != 0);
            apply(a, b);
            chk++;
            if ({bus.req0_ready, bus.req1_ready} !== {e_rdy0, e_rdy1}) begin
                err++; $display("FAIL random_ready n=%0d: got %b%b expected %b%b",
                                n, bus.req0_ready, bus.req1_ready, e_rdy0, e_rdy1);
            end
            advance();
            chk++;
            if (obs_iss !== m_iss) begin
                err++; $display("FAIL random_iss n=%0d: got %h expected %h", n, obs_iss, m_iss);
            end
        end
`ifdef PIPE_PERF_EN
        chk++;
        if (issue_cnt !== 16'(m_issue) || stall_cnt !== 16'(m_stall)) begin
            err++; $display("FAIL random_counters: got %0d/%0d expected %0d/%0d",
                            issue_cnt, stall_cnt, m_issue, m_stall);
        end
`endif
    endtask

    initial begin
        #2;
        test_reset();
        test_alternate();
        test_raw_hazard();
        test_hazard_bypass();
        test_src_decode();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", chk, err);
        $finish;
    end
endmodule
